// File: rtl/cpu_stepper_ctrl_if.sv
// cpu_stepper_ctrl_if
//   Groups the sequencer's control inputs and its routing/strobe outputs.
//   slave  : the sequencer (drives o_*, reads i_*)
//   master : whoever feeds it instructions and consumes the strobes
//   i_run, i_step_req        run level / single-instruction request
//   i_ir[7:0], i_flags[3:0]  data_bus word for IR, ALU flags {C,A>B,EQ,Z}
//   o_step[1:6]              one-hot stepper (bit 1 = step 1)
//   o_instr[0:3]             IR[7:4], bit 0 = MSB
//   o_ir_io, o_flags_detected, load/write strobes, o_bus1, o_busy, o_done
interface cpu_stepper_ctrl_if;
  logic       i_run;
  logic       i_step_req;
  logic [7:0] i_ir;
  logic [3:0] i_flags;
  logic [1:6] o_step;
  logic [0:3] o_instr;
  logic       o_ir_io;
  logic       o_flags_detected;
  logic       o_ld_ir, o_ld_mar, o_ld_iar, o_ld_acc, o_ld_tmp, o_ld_gpr;
  logic       o_we_ram, o_we_io, o_ld_flags;
  logic       o_bus1;
  logic       o_busy;
  logic       o_done;

  modport slave (
    input  i_run, i_step_req, i_ir, i_flags,
    output o_step, o_instr, o_ir_io, o_flags_detected,
           o_ld_ir, o_ld_mar, o_ld_iar, o_ld_acc, o_ld_tmp, o_ld_gpr,
           o_we_ram, o_we_io, o_ld_flags, o_bus1, o_busy, o_done
  );

  modport master (
    output i_run, i_step_req, i_ir, i_flags,
    input  o_step, o_instr, o_ir_io, o_flags_detected,
           o_ld_ir, o_ld_mar, o_ld_iar, o_ld_acc, o_ld_tmp, o_ld_gpr,
           o_we_ram, o_we_io, o_ld_flags, o_bus1, o_busy, o_done
  );
endinterface

// File: rtl/cpu_stepper_ctrl.sv
// cpu_stepper_ctrl
//   Six-step instruction sequencer. Each step is held CYCLES_PER_STEP
//   clocks; load/write strobes are asserted on the last clock of a step so
//   the capturing edge is the one that ends the step. Owns IR and the flag
//   register used for conditional jumps.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cpu_stepper_ctrl_if.slave (see interface header)
module cpu_stepper_ctrl #(
  parameter int CYCLES_PER_STEP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_stepper_ctrl_if.slave   bus
);
  localparam int DIV_W = (CYCLES_PER_STEP > 1) ? $clog2(CYCLES_PER_STEP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CYCLES_PER_STEP - 1);

  typedef enum logic [2:0] {S_IDLE, S_1, S_2, S_3, S_4, S_5, S_6} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       ir_q, ir_d;
  logic [3:0]       flag_q, flag_d;

  logic       last;
  logic [3:0] op;
  logic       fd;
  logic       ld_ir, ld_mar, ld_iar, ld_acc, ld_tmp, ld_gpr;
  logic       we_ram, we_io, ld_flags, bus1;

  assign last = (div_q == DIV_LAST);
  assign op   = ir_q[7:4];
  assign fd   = |(flag_q & ir_q[3:0]);

  // Strobe decode: only on the last clock of a step, and never in IDLE.
  always_comb begin
    ld_ir = 1'b0; ld_mar = 1'b0; ld_iar = 1'b0; ld_acc = 1'b0; ld_tmp = 1'b0;
    ld_gpr = 1'b0; we_ram = 1'b0; we_io = 1'b0; ld_flags = 1'b0; bus1 = 1'b0;
    if (last) begin
      case (state_q)
        S_1: begin ld_mar = 1'b1; ld_acc = 1'b1; bus1 = 1'b1; end
        S_2: ld_ir  = 1'b1;
        S_3: ld_iar = 1'b1;
        S_4: begin
          if (op[3]) ld_tmp = 1'b1;
          else begin
            case (op[2:0])
              3'd0, 3'd1, 3'd4: ld_mar = 1'b1;
              3'd2, 3'd5: begin ld_mar = 1'b1; ld_acc = 1'b1; bus1 = 1'b1; end
              3'd3: ld_iar   = 1'b1;
              3'd6: ld_flags = 1'b1;
              default: we_io = ir_q[3];
            endcase
          end
        end
        S_5: begin
          if (op[3]) begin ld_acc = 1'b1; ld_flags = 1'b1; end
          else begin
            case (op[2:0])
              3'd0, 3'd2: ld_gpr = 1'b1;
              3'd1:       we_ram = 1'b1;
              3'd4, 3'd5: ld_iar = 1'b1;
              3'd7:       ld_gpr = !ir_q[3];
              default: ;
            endcase
          end
        end
        S_6: begin
          if (op[3])          ld_gpr = (op != 4'hF);  // CMP only sets flags
          else if (op == 4'h2) ld_iar = 1'b1;          // skip past DATA word
          else if (op == 4'h5) ld_iar = fd;            // taken conditional jump
        end
        default: ;
      endcase
    end
  end

  // Next-state: step advances on the last divider clock; step 6 wraps to
  // step 1 only while i_run is held, so a request during busy is dropped.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ir_d    = ld_ir    ? bus.i_ir    : ir_q;
    flag_d  = ld_flags ? bus.i_flags : flag_q;
    if (state_q == S_IDLE) begin
      div_d = '0;
      if (bus.i_run || bus.i_step_req) state_d = S_1;
    end else if (!last) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d = '0;
      case (state_q)
        S_1: state_d = S_2;
        S_2: state_d = S_3;
        S_3: state_d = S_4;
        S_4: state_d = S_5;
        S_5: state_d = S_6;
        default: state_d = bus.i_run ? S_1 : S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      ir_q    <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    bus.o_step = '0;
    case (state_q)
      S_1: bus.o_step[1] = 1'b1;
      S_2: bus.o_step[2] = 1'b1;
      S_3: bus.o_step[3] = 1'b1;
      S_4: bus.o_step[4] = 1'b1;
      S_5: bus.o_step[5] = 1'b1;
      S_6: bus.o_step[6] = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_instr          = ir_q[7:4];
  assign bus.o_ir_io          = ir_q[3];
  assign bus.o_flags_detected = fd;
  assign bus.o_ld_ir          = ld_ir;
  assign bus.o_ld_mar         = ld_mar;
  assign bus.o_ld_iar         = ld_iar;
  assign bus.o_ld_acc         = ld_acc;
  assign bus.o_ld_tmp         = ld_tmp;
  assign bus.o_ld_gpr         = ld_gpr;
  assign bus.o_we_ram         = we_ram;
  assign bus.o_we_io          = we_io;
  assign bus.o_ld_flags       = ld_flags;
  assign bus.o_bus1           = bus1;
  assign bus.o_busy           = (state_q != S_IDLE);
  assign bus.o_done           = (state_q == S_6) && last;
endmodule

// File: tb/tb_cpu_stepper_ctrl.sv
module tb_cpu_stepper_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_stepper_ctrl_if ifa ();
  cpu_stepper_ctrl_if ifb ();

  cpu_stepper_ctrl #(.CYCLES_PER_STEP(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  cpu_stepper_ctrl #(.CYCLES_PER_STEP(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_assert = 0;
  int n_fail   = 0;
  int sel      = 0;           // 0: dut_a (1 clk/step), 1: dut_b (3 clk/step)
  logic [3:0] mflags [2];     // model of each DUT's flag register

  // Strobe vector bit order used by the bench
  localparam logic [9:0] K_IR = 10'h200, K_MAR = 10'h100, K_IAR = 10'h080,
                         K_ACC = 10'h040, K_TMP = 10'h020, K_GPR = 10'h010,
                         K_RAM = 10'h008, K_IO  = 10'h004, K_FLG = 10'h002,
                         K_B1  = 10'h001;

  logic [1:6] obs_step;
  logic [9:0] obs_strb;
  logic       obs_busy, obs_done, obs_ir_io, obs_fd;
  logic [3:0] obs_instr;

  always_comb begin
    if (sel == 1) begin
      obs_step  = ifb.o_step;  obs_busy = ifb.o_busy; obs_done = ifb.o_done;
      obs_instr = ifb.o_instr; obs_ir_io = ifb.o_ir_io; obs_fd = ifb.o_flags_detected;
      obs_strb  = {ifb.o_ld_ir, ifb.o_ld_mar, ifb.o_ld_iar, ifb.o_ld_acc, ifb.o_ld_tmp,
                   ifb.o_ld_gpr, ifb.o_we_ram, ifb.o_we_io, ifb.o_ld_flags, ifb.o_bus1};
    end else begin
      obs_step  = ifa.o_step;  obs_busy = ifa.o_busy; obs_done = ifa.o_done;
      obs_instr = ifa.o_instr; obs_ir_io = ifa.o_ir_io; obs_fd = ifa.o_flags_detected;
      obs_strb  = {ifa.o_ld_ir, ifa.o_ld_mar, ifa.o_ld_iar, ifa.o_ld_acc, ifa.o_ld_tmp,
                   ifa.o_ld_gpr, ifa.o_we_ram, ifa.o_we_io, ifa.o_ld_flags, ifa.o_bus1};
    end
  end

  // Reference: which strobes the instruction table asks for at a given step.
  function automatic logic [9:0] exp_strb(input int s, input logic [7:0] ir, input logic [3:0] fr);
    logic [3:0] op;
    logic       taken;
    op    = ir[7:4];
    taken = (fr & ir[3:0]) != 4'h0;
    if (s == 1) return K_MAR | K_ACC | K_B1;
    if (s == 2) return K_IR;
    if (s == 3) return K_IAR;
    if (op >= 4'h8) begin
      if (s == 4) return K_TMP;
      if (s == 5) return K_ACC | K_FLG;
      return (op == 4'hF) ? 10'h0 : K_GPR;
    end
    case (op)
      4'h0: return (s == 4) ? K_MAR : (s == 5) ? K_GPR : 10'h0;
      4'h1: return (s == 4) ? K_MAR : (s == 5) ? K_RAM : 10'h0;
      4'h2: return (s == 4) ? (K_MAR | K_ACC | K_B1) : (s == 5) ? K_GPR : K_IAR;
      4'h3: return (s == 4) ? K_IAR : 10'h0;
      4'h4: return (s == 4) ? K_MAR : (s == 5) ? K_IAR : 10'h0;
      4'h5: return (s == 4) ? (K_MAR | K_ACC | K_B1) : (s == 5) ? K_IAR : (taken ? K_IAR : 10'h0);
      4'h6: return (s == 4) ? K_FLG : 10'h0;
      default: begin
        if (s == 4) return ir[3] ? K_IO : 10'h0;
        if (s == 5) return ir[3] ? 10'h0 : K_GPR;
        return 10'h0;
      end
    endcase
  endfunction

  task automatic set_run(input logic v);
    if (sel == 1) ifb.i_run = v; else ifa.i_run = v;
  endtask

  task automatic set_req(input logic v);
    if (sel == 1) ifb.i_step_req = v; else ifa.i_step_req = v;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    ifa.i_step_req = 1'b0;
    ifb.i_step_req = 1'b0;
  endtask

  // Issue a single-instruction request from IDLE; returns in step 1, clock 0.
  task automatic start_req();
    set_req(1'b1);
    tick();
  endtask

  // Walk one instruction from step 1 clock 0 to the edge that ends step 6.
  task automatic check_instr(input logic [7:0] ir, input logic [3:0] fl,
                             input bit drop_run, input bit poke, input string nm);
    logic [1:6] es;
    logic [9:0] exs;
    int cps;
    cps = (sel == 1) ? 3 : 1;
    ifa.i_ir = ir; ifb.i_ir = ir; ifa.i_flags = fl; ifb.i_flags = fl;
    for (int s = 1; s <= 6; s++) begin
      for (int c = 0; c < cps; c++) begin
        es = '0; es[s] = 1'b1;
        exs = (c == cps - 1) ? exp_strb(s, ir, mflags[sel]) : 10'h0;
        n_assert++;
        if (obs_step !== es) begin
          n_fail++; $display("FAIL %s step s%0d c%0d: got %b want %b", nm, s, c, obs_step, es);
        end
        n_assert++;
        if (obs_busy !== 1'b1) begin
          n_fail++; $display("FAIL %s busy s%0d c%0d: got %b want 1", nm, s, c, obs_busy);
        end
        n_assert++;
        if (obs_strb !== exs) begin
          n_fail++; $display("FAIL %s strobes s%0d c%0d: got %b want %b", nm, s, c, obs_strb, exs);
        end
        n_assert++;
        if (obs_done !== (s == 6 && c == cps - 1)) begin
          n_fail++; $display("FAIL %s done s%0d c%0d: got %b", nm, s, c, obs_done);
        end
        if (s == 3 && c == 0) begin
          n_assert++;
          if (obs_instr !== ir[7:4] || obs_ir_io !== ir[3]) begin
            n_fail++; $display("FAIL %s instr/io: got %h/%b want %h/%b", nm, obs_instr, obs_ir_io, ir[7:4], ir[3]);
          end
        end
        if (s == 6 && c == 0 && ir[7:4] == 4'h5) begin
          n_assert++;
          if (obs_fd !== ((mflags[sel] & ir[3:0]) != 4'h0)) begin
            n_fail++; $display("FAIL %s flags_detected: got %b flags %b", nm, obs_fd, mflags[sel]);
          end
        end
        if ((exs & K_FLG) != 10'h0) mflags[sel] = fl;
        if (drop_run && s == 2 && c == 0) set_run(1'b0);
        if (poke && s == 3 && c == 0) set_req(1'b1);
        tick();
      end
    end
  endtask

  task automatic check_idle(input string nm);
    n_assert++;
    if (obs_step !== 6'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_strb !== 10'h0) begin
      n_fail++;
      $display("FAIL %s idle: step %b busy %b done %b strb %b want all 0", nm, obs_step, obs_busy, obs_done, obs_strb);
    end
  endtask

  task automatic test_reset();
    #3;
    check_idle("reset");
    n_assert++;
    if (ifa.o_instr !== 4'h0 || ifb.o_instr !== 4'h0) begin
      n_fail++; $display("FAIL reset instr: got %h/%h want 0", ifa.o_instr, ifb.o_instr);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    check_idle("reset_release");
  endtask

  task automatic test_alu();
    sel = 0;
    start_req();
    check_instr(8'h81, 4'b1000, 0, 0, "alu");
    check_idle("alu_end");
    tick();
    check_idle("alu_stay");
  endtask

  task automatic test_cmp();
    sel = 0;
    start_req();
    check_instr(8'hF1, 4'b0010, 0, 0, "cmp");
    check_idle("cmp_end");
  endtask

  task automatic test_jcaz();
    sel = 0;
    start_req(); check_instr(8'h81, 4'b1000, 0, 0, "jc_setup");
    start_req(); check_instr(8'h58, 4'($urandom), 0, 0, "jc_taken");
    start_req(); check_instr(8'h60, 4'b0000, 0, 0, "clf");
    start_req(); check_instr(8'h58, 4'($urandom), 0, 0, "jc_not");
    check_idle("jc_end");
  endtask

  task automatic test_io();
    sel = 0;
    start_req(); check_instr(8'h78, 4'h0, 0, 1, "io_out");
    check_idle("io_req_ignored");
    tick();
    check_idle("io_req_ignored2");
    start_req(); check_instr(8'h70, 4'h0, 0, 0, "io_in");
    check_idle("io_in_end");
  endtask

  task automatic test_mid_reset();
    sel = 0;
    ifa.i_ir = 8'h23;
    start_req();
    tick(); tick();           // now in step 3
    #2 rst_n = 1'b0;
    #1;
    check_idle("midrst");
    n_assert++;
    if (ifa.o_instr !== 4'h0 || ifa.o_ir_io !== 1'b0) begin
      n_fail++; $display("FAIL midrst ir: got %h/%b want 0/0", ifa.o_instr, ifa.o_ir_io);
    end
    mflags[0] = 4'h0; mflags[1] = 4'h0;
    @(negedge clk); rst_n = 1'b1; ifa.i_run = 1'b1;
    tick();
    check_instr(8'h91, 4'b0101, 1, 0, "midrst_run");
    check_idle("midrst_end");
  endtask

  task automatic test_random();
    sel = 0;
    for (int i = 0; i < 30; i++) begin
      start_req();
      check_instr(8'($urandom), 4'($urandom), 0, 0, "rand");
    end
    check_idle("rand_end");
  endtask

  task automatic test_back_to_back();
    sel = 1;
    set_run(1'b1);
    tick();
    check_instr(8'h81, 4'b1000, 0, 0, "b2b_0");
    check_instr(8'h5C, 4'($urandom), 0, 0, "b2b_1");
    check_instr(8'($urandom), 4'($urandom), 1, 0, "b2b_2");
    check_idle("b2b_end");
    tick();
    check_idle("b2b_stay");
  endtask

  initial begin
    ifa.i_run = 1'b0; ifa.i_step_req = 1'b0; ifa.i_ir = 8'h0; ifa.i_flags = 4'h0;
    ifb.i_run = 1'b0; ifb.i_step_req = 1'b0; ifb.i_ir = 8'h0; ifb.i_flags = 4'h0;
    mflags[0] = 4'h0; mflags[1] = 4'h0;
    test_reset();
    test_alu();
    test_cmp();
    test_jcaz();
    test_io();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
